pc_sequencer: RTL and testbench



---
 rtl/mips_pkg.sv | 25 ++
 rtl/npc_calc.sv | 48 ++++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
// FSM states, next-PC select codes and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_JMP = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extend a 16-bit word offset to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculator: sequential, branch, jump and jump-register.
// Purely combinational; jr beats jmp beats br_taken beats sequential.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_target26,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] pc1;
    npc_sel_e    sel;

    assign pc1 = pc + 32'd1;

    // Resolve the redirect source by fixed priority
    always_comb begin
        sel = NPC_SEQ;
        if (jr) begin
            sel = NPC_JR;
        end else if (jmp) begin
            sel = NPC_JMP;
        end else if (br_taken) begin
            sel = NPC_BR;
        end
    end

    // Form the target address for the selected source
    always_comb begin
        next_pc = pc1;
        unique case (sel)
            NPC_SEQ: next_pc = pc1;
            NPC_BR:  next_pc = pc1 + sext16(br_imm);
            NPC_JMP: next_pc = {pc1[31:26], jmp_target26};
            NPC_JR:  next_pc = jr_addr;
            default: next_pc = pc1;
        endcase
    end

    assign redirect = (sel != NPC_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: PC register, imem handshake, decode issue.
// Define DELAY_SLOT_EN to make redirects take effect after one delay slot.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_target26,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] instr_count
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;
    logic        redirect;

`ifdef DELAY_SLOT_EN
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] seq_pc;

    assign seq_pc = pc_q + 32'd1;
`else
    logic        unused_redirect;

    assign unused_redirect = redirect;
`endif

    npc_calc u_npc (
        .pc           (pc_q),
        .br_taken     (br_taken),
        .br_imm       (br_imm),
        .jmp          (jmp),
        .jmp_target26 (jmp_target26),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .next_pc      (next_pc),
        .redirect     (redirect)
    );

    // Next state, PC update and instruction capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
`ifdef DELAY_SLOT_EN
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
`endif
        unique case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
                pc_d    = RESET_PC;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    state_d = ST_FETCH;
                    count_d = count_q + 32'd1;
`ifdef DELAY_SLOT_EN
                    if (pend_valid_q) begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else if (redirect) begin
                        pc_d         = seq_pc;
                        pend_valid_d = 1'b1;
                        pend_pc_d    = next_pc;
                    end else begin
                        pc_d = next_pc;
                    end
`else
                    pc_d = next_pc;
`endif
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            count_q <= 32'd0;
`ifdef DELAY_SLOT_EN
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
`ifdef DELAY_SLOT_EN
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
`endif
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign instr       = instr_q;
    assign pc_out      = pc_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with directed fetch/issue vectors.
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        br_taken = 1'b0;
    logic [15:0] br_imm = 16'd0;
    logic        jmp = 1'b0;
    logic [25:0] jmp_target26 = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = 32'd0;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .pc_out       (pc_out),
        .br_taken     (br_taken),
        .br_imm       (br_imm),
        .jmp          (jmp),
        .jmp_target26 (jmp_target26),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .instr_count  (instr_count)
    );

    typedef struct {
        logic [31:0] addr;
        int          ack_dly;
        int          rdy_dly;
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] t26;
        logic        jr;
        logic [31:0] jra;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] cnt;
    } iss_t;

    logic [31:0] exp_fetch[$];
    iss_t        exp_iss[$];
    vec_t        vecs[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] cnt_model = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input int ad, input int rd,
                       input logic br, input logic [15:0] imm,
                       input logic jm, input logic [25:0] t26,
                       input logic j, input logic [31:0] jra);
        vec_t v;
        v.addr = a; v.ack_dly = ad; v.rdy_dly = rd;
        v.br = br; v.imm = imm; v.jmp = jm; v.t26 = t26;
        v.jr = j; v.jra = jra;
        vecs.push_back(v);
    endtask

    task automatic garbage_redirect();
        jr = 1'b1; jr_addr = 32'hBAD0_0000;
        jmp = 1'b1; jmp_target26 = 26'h3FF_FFFF;
        br_taken = 1'b1; br_imm = 16'h7777;
    endtask

    task automatic clear_redirect();
        jr = 1'b0; jr_addr = 32'd0;
        jmp = 1'b0; jmp_target26 = 26'd0;
        br_taken = 1'b0; br_imm = 16'd0;
    endtask

    // Drive one fetch + issue transaction; caller sits at posedge+1
    task automatic run_instr(input vec_t v);
        int   n;
        iss_t e;
        exp_fetch.push_back(v.addr);
        e.pc = v.addr; e.ins = mem_word(v.addr); e.cnt = cnt_model;
        exp_iss.push_back(e);
        cnt_model = cnt_model + 32'd1;
        garbage_redirect();
        n = 0;
        while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
        if (!imem_req) begin
            n_chk++; n_fail++;
            $display("FAIL req_timeout: got 0 expected 1");
            return;
        end
        repeat (v.ack_dly) begin @(posedge clk); #1; end
        imem_ack = 1'b1;
        imem_rdata = mem_word(v.addr);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        imem_rdata = 32'hFFFF_0000;
        n = 0;
        while (!instr_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!instr_valid) begin
            n_chk++; n_fail++;
            $display("FAIL valid_timeout: got 0 expected 1");
            return;
        end
        repeat (v.rdy_dly) begin @(posedge clk); #1; end
        instr_ready = 1'b1;
        br_taken = v.br; br_imm = v.imm;
        jmp = v.jmp; jmp_target26 = v.t26;
        jr = v.jr; jr_addr = v.jra;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        clear_redirect();
    endtask

    // Monitor: compare fetch address and issued word against the queues
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req) begin
                if (exp_fetch.size() == 0) begin
                    if (imem_ack) begin
                        n_chk++; n_fail++;
                        $display("FAIL fetch_unexpected: got %h expected none", imem_addr);
                    end
                end else begin
                    chk(imem_ack ? "fetch_addr" : "fetch_hold", imem_addr, exp_fetch[0]);
                    if (imem_ack) void'(exp_fetch.pop_front());
                end
            end
            if (instr_valid) begin
                if (exp_iss.size() == 0) begin
                    if (instr_ready) begin
                        n_chk++; n_fail++;
                        $display("FAIL issue_unexpected: got %h expected none", pc_out);
                    end
                end else begin
                    chk(instr_ready ? "issue_pc" : "hold_pc", pc_out, exp_iss[0].pc);
                    chk(instr_ready ? "issue_instr" : "hold_instr", instr, exp_iss[0].ins);
                    chk("instr_count", instr_count, exp_iss[0].cnt);
                    if (instr_ready) void'(exp_iss.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DELAY_SLOT_EN
        add(32'h0000_0000, 0, 1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h10);
        add(32'h0000_0001, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0010, 1, 0, 1'b0, 16'h0, 1'b1, 26'h80, 1'b0, 32'h0);
        add(32'h0000_0011, 0, 2, 1'b1, 16'h100, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0080, 2, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0081, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h500);
`else
        add(32'h0000_0000, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0001, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0002, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0003, 3, 2, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0005);
        add(32'h1000_0005, 0, 0, 1'b1, 16'hFFFA, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h1000_0000, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFC00_0010);
        add(32'hFC00_0010, 1, 1, 1'b0, 16'h0, 1'b1, 26'h0000123, 1'b0, 32'h0);
        add(32'hFC00_0123, 0, 0, 1'b1, 16'h0005, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h40);
        add(32'h0000_0040, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFF);
        add(32'hFFFF_FFFF, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0000, 0, 0, 1'b1, 16'h0007, 1'b1, 26'h200, 1'b0, 32'h0);
        add(32'h0000_0200, 0, 0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0204, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr_count", instr_count, 32'd0);
        reset = 1'b0;
        foreach (vecs[i]) run_instr(vecs[i]);

        // Abort an outstanding fetch: reset with a same-cycle ack
        while (!imem_req) begin @(posedge clk); #1; end
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        reset = 1'b0;
        imem_ack = 1'b0;
        chk("abort_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("abort_imem_req", {31'd0, imem_req}, 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_instr_count", instr_count, 32'd0);
        chk("abort_imem_addr", imem_addr, 32'h0);
        cnt_model = 32'd0;
        vecs.delete();
        add(32'h0000_0000, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0001, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        add(32'h0000_0002, 0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        foreach (vecs[i]) run_instr(vecs[i]);
        chk("final_count", instr_count, 32'd3);
        chk("fetch_queue_empty", exp_fetch.size(), 32'd0);
        chk("issue_queue_empty", exp_iss.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
